// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C command port among NUM_REQ sequencers.
// One transaction at a time, with a completion timeout and an enforced idle gap afterwards.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int GAP_CYCLES     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_id,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [NUM_REQ-1:0]     rsp_err,
  output logic [7:0]             rsp_rdata,
  output logic                   busy,
  output logic [7:0]             dbg_cstate,
  output logic                   IO_CONTROL_PULSE,
  output logic                   IO_CONTROL_RW,
  output logic [7:0]             IO_CONTROL_ID,
  output logic [7:0]             IO_ADDR_ADDR,
  output logic [7:0]             IO_WDATA_WDATA,
  input  logic [7:0]             IO_RDATA_RDATA,
  input  logic                   IO_CONTROL_CMPLT
);
  localparam int          IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] GAP = 32'(GAP_CYCLES);

  typedef enum logic [7:0] {
    S_IDLE  = 8'h00,
    S_ISSUE = 8'h01,
    S_WAIT  = 8'h02,
    S_RESP  = 8'h03,
    S_GAP   = 8'h04
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t [NUM_REQ-1:0] req_cmd;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_cmd[i] = {req_rw[i], req_id[8*i +: 8], req_addr[8*i +: 8], req_wdata[8*i +: 8]};
  end

  state_t               state_q;
  logic [IW-1:0]        last_q;
  logic [IW-1:0]        owner_q;
  logic [31:0]          cnt_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   err_q;
  logic [7:0]           rdata_q;
  logic                 pulse_q;
  cmd_t                 io_q;

  logic [IW-1:0]        win;
  logic [IW-1:0]        cand;

  // Walk the search order backwards so the nearest pending requester after last_q wins.
  always_comb begin
    win  = last_q;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[cand]) win = cand;
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      pulse_q <= 1'b0;
      io_q    <= '0;
    end else begin
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            state_q <= S_ISSUE;
            last_q  <= win;
            owner_q <= win;
            io_q    <= req_cmd[win];
            pulse_q <= 1'b1;
            ready_q <= onehot(win);
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= TMO;
        end
        S_WAIT: begin
          // Completion takes priority over a timer expiring in the same cycle.
          if (IO_CONTROL_CMPLT) begin
            rdata_q <= IO_RDATA_RDATA;
            done_q  <= onehot(owner_q);
            state_q <= S_RESP;
          end else if ((TMO != 32'd0) && (cnt_q == 32'd0)) begin
            rdata_q <= '0;
            done_q  <= onehot(owner_q);
            err_q   <= onehot(owner_q);
            state_q <= S_RESP;
          end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_RESP: begin
          if (GAP != 32'd0) begin
            state_q <= S_GAP;
            cnt_q   <= GAP - 32'd1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt_q == 32'd0) state_q <= S_IDLE;
          else                cnt_q   <= cnt_q - 32'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready        = ready_q;
  assign rsp_done         = done_q;
  assign rsp_err          = err_q;
  assign rsp_rdata        = rdata_q;
  assign busy             = (state_q != S_IDLE);
  assign dbg_cstate       = state_q;
  assign IO_CONTROL_PULSE = pulse_q;
  assign IO_CONTROL_RW    = io_q.rw;
  assign IO_CONTROL_ID    = io_q.id;
  assign IO_ADDR_ADDR     = io_q.addr;
  assign IO_WDATA_WDATA   = io_q.wdata;

endmodule
